// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for N_DISP 7-segment displays sharing one digit index.
// Each display decodes its own digit; the shadow buffer swaps only at frame end so a scan never tears.
module seg_disp_lane #(
  parameter int N_DIGITS = 4,
  parameter int IW       = 2
) (
  input  logic [N_DIGITS-1:0][3:0] nib_i,
  input  logic [N_DIGITS-1:0]      dp_i,
  input  logic [N_DIGITS-1:0]      blink_i,
  input  logic                     lz_i,
  input  logic                     show_i,
  input  logic                     phase_i,
  input  logic [IW-1:0]            idx_i,
  output logic [7:0]               seg_o,
  output logic [N_DIGITS-1:0]      an_o
);
  logic [N_DIGITS-1:0] lead;
  logic                acc;
  logic [3:0]          cur;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    // lead[k]: digit k and every digit above it are zero
    lead = '0;
    acc  = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      acc     = acc & (nib_i[k] == 4'h0);
      lead[k] = acc;
    end
    cur   = nib_i[idx_i];
    seg_o = 8'hFF;
    an_o  = '1;
    if (show_i) begin
      an_o[idx_i] = 1'b0;
      if (blink_i[idx_i] && phase_i)
        seg_o = 8'hFF;
      else if (lz_i && (idx_i != '0) && lead[idx_i])
        seg_o = {~dp_i[idx_i], 7'h7F};
      else
        seg_o = {~dp_i[idx_i], hex7(cur)};
    end
  end
endmodule

module seg_scan_ctrl #(
  parameter int N_DISP    = 2,
  parameter int N_DIGITS  = 4,
  parameter int SHOW_CYC  = 131072,
  parameter int BLANK_CYC = 256,
  parameter int BLINK_CYC = 25000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         load,
  input  logic [N_DISP*N_DIGITS*4-1:0] data,
  input  logic [N_DISP*N_DIGITS-1:0]   dp,
  input  logic [N_DISP*N_DIGITS-1:0]   blink_mask,
  input  logic [N_DISP-1:0]            lz_blank,
  output logic [N_DISP*N_DIGITS-1:0]   an,
  output logic [N_DISP*8-1:0]          seg,
  output logic                         frame_done
);
  localparam int NB = N_DISP * N_DIGITS;
  localparam int TW = $clog2((SHOW_CYC > BLANK_CYC ? SHOW_CYC : BLANK_CYC) + 1);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW = $clog2(BLINK_CYC + 1);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_CYC - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;
  typedef struct packed {
    logic [NB*4-1:0] data;
    logic [NB-1:0]   dp;
    logic [NB-1:0]   blink;
  } buf_t;

  state_t  state_q;
  logic [TW-1:0] tmr_q;
  logic [IW-1:0] idx_q;
  logic [BW-1:0] bcnt_q;
  logic          phase_q;
  buf_t          shadow_q, pending_q, in_buf;
  logic          pend_q;
  logic          show, frame_end;
  logic [N_DISP-1:0][N_DIGITS-1:0] an_d, an_q;
  logic [N_DISP-1:0][7:0]          seg_d, seg_q;

  assign in_buf     = {data, dp, blink_mask};
  assign show       = (state_q == SHOW);
  assign frame_end  = show && en && (tmr_q == SHOW_LAST) && (idx_q == IDX_LAST);
  assign frame_done = frame_end;
  assign an         = an_q;
  assign seg        = seg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      tmr_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= '1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      case (state_q)
        OFF: if (en) begin
          state_q <= BLANK;
          idx_q   <= '0;
          tmr_q   <= '0;
        end
        BLANK: if (!en) state_q <= OFF;
          else if (tmr_q == BLANK_LAST) begin
            state_q <= SHOW;
            tmr_q   <= '0;
          end else tmr_q <= tmr_q + 1'b1;
        SHOW: if (!en) state_q <= OFF;
          else if (tmr_q == SHOW_LAST) begin
            state_q <= BLANK;
            tmr_q   <= '0;
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else tmr_q <= tmr_q + 1'b1;
        default: state_q <= OFF;
      endcase
    end
  end

  // Writes while dark or on the frame boundary bypass the pending stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
    end else if (load && (state_q == OFF || frame_end)) begin
      shadow_q  <= in_buf;
      pending_q <= in_buf;
      pend_q    <= 1'b0;
    end else if (load) begin
      pending_q <= in_buf;
      pend_q    <= 1'b1;
    end else if (frame_end && pend_q) begin
      shadow_q <= pending_q;
      pend_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (bcnt_q == BLINK_LAST) begin
      bcnt_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      bcnt_q <= bcnt_q + 1'b1;
    end
  end

  for (genvar d = 0; d < N_DISP; d++) begin : g_disp
    seg_disp_lane #(.N_DIGITS(N_DIGITS), .IW(IW)) u_lane (
      .nib_i   (shadow_q.data[d*N_DIGITS*4 +: N_DIGITS*4]),
      .dp_i    (shadow_q.dp[d*N_DIGITS +: N_DIGITS]),
      .blink_i (shadow_q.blink[d*N_DIGITS +: N_DIGITS]),
      .lz_i    (lz_blank[d]),
      .show_i  (show),
      .phase_i (phase_q),
      .idx_i   (idx_q),
      .seg_o   (seg_d[d]),
      .an_o    (an_d[d])
    );
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: scan order, lead-zero blanking, double buffering, blink/dp, reset/enable.
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [31:0] data;
  logic [7:0]  dp, blink_mask, an;
  logic [1:0]  lz_blank;
  logic [15:0] seg;
  logic        frame_done;
  int          n_tests = 0, n_fail = 0, t = 0;

  seg_scan_ctrl #(.N_DISP(2), .N_DIGITS(4), .SHOW_CYC(8), .BLANK_CYC(2), .BLINK_CYC(64)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp(dp),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    t += n;
  endtask

  task automatic upto(input int target);
    adv(target - t);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; data = '0; dp = '0; blink_mask = '0; lz_blank = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'hFFFF);
    chk("rst_fd", 32'(frame_done), 32'h0);

    // Load while dark, then scan 0x89AB_1234
    rst = 1'b0; data = 32'h89AB_1234; load = 1'b1;
    adv(1); load = 1'b0;
    chk("off_load_pend", 32'(dut.pend_q), 32'h0);
    chk("off_dark", 32'(an), 32'hFF);
    en = 1'b1; t = 0;
    upto(3);   chk("an_reg_lag", 32'(an), 32'hFF);
    upto(4);   chk("d0_an", 32'(an), 32'hEE);  chk("d0_seg", 32'(seg), 32'h8399);
    upto(11);  chk("d0_last", 32'(an), 32'hEE);
    upto(12);  chk("gap_an", 32'(an), 32'hFF); chk("gap_seg", 32'(seg), 32'hFFFF);
    upto(14);  chk("d1_an", 32'(an), 32'hDD);  chk("d1_seg", 32'(seg), 32'h88B0);
    upto(24);  chk("d2_an", 32'(an), 32'hBB);  chk("d2_seg", 32'(seg), 32'h90A4);
    upto(34);  chk("d3_an", 32'(an), 32'h77);  chk("d3_seg", 32'(seg), 32'h80F9);
    upto(39);  chk("fd_pre", 32'(frame_done), 32'h0);
    upto(40);  chk("fd_1", 32'(frame_done), 32'h1);
    upto(41);  chk("fd_post", 32'(frame_done), 32'h0);

    // Mid-frame load is held until the frame boundary
    upto(45); data = 32'h89AB_1111; load = 1'b1;
    adv(1); load = 1'b0;
    chk("mid_pend", 32'(dut.pend_q), 32'h1);
    upto(54);  chk("mid_old_d1", 32'(seg), 32'h88B0);
    upto(74);  chk("mid_old_d3", 32'(seg), 32'h80F9);
    upto(80);  chk("fd_2", 32'(frame_done), 32'h1);
    upto(81);  chk("swap_pend", 32'(dut.pend_q), 32'h0);
    upto(84);  chk("new_d0", 32'(seg), 32'h83F9);
    upto(94);  chk("new_d1", 32'(seg), 32'h88F9);

    // Load exactly on the frame-end cycle
    upto(120); chk("fd_3", 32'(frame_done), 32'h1);
    data = 32'h89AB_2222; load = 1'b1;
    adv(1); load = 1'b0;
    chk("coinc_pend", 32'(dut.pend_q), 32'h0);
    upto(124); chk("coinc_d0", 32'(seg), 32'h83A4);
    en = 1'b0;
    upto(126); chk("en_off_an", 32'(an), 32'hFF); chk("en_off_seg", 32'(seg), 32'hFFFF);

    // Leading-zero suppression on display 0 only
    data = 32'h0000_0050; lz_blank = 2'b01; load = 1'b1;
    adv(1); load = 1'b0; en = 1'b1; t = 0;
    upto(4);   chk("lz_d0_an", 32'(an), 32'hEE); chk("lz_d0", 32'(seg), 32'hC0C0);
    upto(14);  chk("lz_d1", 32'(seg), 32'hC092);
    upto(24);  chk("lz_d2", 32'(seg), 32'hC0FF);
    upto(34);  chk("lz_d3", 32'(seg), 32'hC0FF);
    upto(36);  chk("pre_rst_an", 32'(an), 32'h77);

    // Asynchronous reset mid-SHOW
    rst = 1'b1; #1;
    chk("arst_an", 32'(an), 32'hFF);
    chk("arst_seg", 32'(seg), 32'hFFFF);
    chk("arst_fd", 32'(frame_done), 32'h0);
    en = 1'b0; lz_blank = 2'b00;
    adv(2);

    // Blink + dp: phase flips every 64 cycles from reset release
    rst = 1'b0; data = 32'h0000_0005; dp = 8'h01; blink_mask = 8'h01; load = 1'b1;
    adv(1); load = 1'b0; en = 1'b1; t = 0;
    upto(4);   chk("blk_ph0", 32'(seg), 32'hC012);
    upto(44);  chk("blk_ph0_f1", 32'(seg), 32'hC012);
    upto(84);  chk("blk_ph1", 32'(seg), 32'hC0FF); chk("blk_an", 32'(an), 32'hEE);
    upto(127); chk("blk_ph1_end", 32'(seg), 32'hC0FF);
    upto(128); chk("blk_ph0_again", 32'(seg), 32'hC012);

    // Reset with en held high restarts at BLANK idx 0 with cleared buffers
    upto(130); rst = 1'b1; #1;
    chk("arst2_an", 32'(an), 32'hFF);
    adv(2);
    rst = 1'b0; t = 0;
    upto(3);   chk("restart_blank", 32'(an), 32'hFF);
    upto(4);   chk("restart_an", 32'(an), 32'hEE); chk("restart_seg", 32'(seg), 32'hC0C0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
